// File: rtl/clk_gen_multi.sv
// Multi-channel clock divider / strobe generator: CH independent channels, each
// producing a 50%-duty toggle clock or a one-cycle pulse, with glitch-free reloads.
module clk_gen_multi #(
   parameter int unsigned CH      = 4,
   parameter int unsigned COUNT_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CH-1:0]         en_i,
   input  logic                  sync_i,
   input  logic [CH-1:0]         mode_i,
   input  logic [CH*COUNT_W-1:0] count_i,
   output logic [CH-1:0]         clk_o,
   output logic [CH-1:0]         tick_o
);

   localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic [COUNT_W-1:0] cnt     [CH];
   logic [COUNT_W-1:0] act_cnt [CH];
   logic [CH-1:0]      act_mode;
   logic [CH-1:0]      clk_q;
   logic [CH-1:0]      tick_q;

   // Shadow count/mode load only at terminal, or while the counter is parked at
   // zero (sync/disabled), so the counter can never run past its terminal value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned c = 0; c < CH; c++) begin
            cnt[c]     <= '0;
            act_cnt[c] <= '0;
         end
         act_mode <= '0;
         clk_q    <= '0;
         tick_q   <= '0;
      end else begin
         for (int unsigned c = 0; c < CH; c++) begin
            if (sync_i || !en_i[c]) begin
               cnt[c]      <= '0;
               clk_q[c]    <= 1'b0;
               tick_q[c]   <= 1'b0;
               act_cnt[c]  <= count_i[c*COUNT_W +: COUNT_W];
               act_mode[c] <= mode_i[c];
            end else if (cnt[c] == act_cnt[c]) begin
               cnt[c]      <= '0;
               tick_q[c]   <= 1'b1;
               clk_q[c]    <= act_mode[c] ? 1'b1 : ~clk_q[c];
               act_cnt[c]  <= count_i[c*COUNT_W +: COUNT_W];
               act_mode[c] <= mode_i[c];
            end else begin
               cnt[c]    <= cnt[c] + ONE;
               tick_q[c] <= 1'b0;
               if (act_mode[c]) begin
                  clk_q[c] <= 1'b0;
               end
            end
         end
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: countdown-based reference model compared
// every cycle, directed scenarios pinned by hand-computed literals, random stimulus.
module tb_clk_gen_multi;

   localparam int unsigned CH = 4;
   localparam int unsigned CW = 16;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic [CH-1:0]      en_i  = '0;
   logic               sync_i = 1'b0;
   logic [CH-1:0]      mode_i = '0;
   logic [CH*CW-1:0]   count_i = '0;
   logic [CH-1:0]      clk_o;
   logic [CH-1:0]      tick_o;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   clk_gen_multi #(.CH(CH), .COUNT_W(CW)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .sync_i  (sync_i),
      .mode_i  (mode_i),
      .count_i (count_i),
      .clk_o   (clk_o),
      .tick_o  (tick_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: each channel keeps the number of edges left before its terminal.
   int unsigned   m_left [CH];
   logic [CH-1:0] m_mode;
   logic [CH-1:0] m_clk;
   logic [CH-1:0] m_tick;

   always @(posedge clk_i or posedge rst_i) begin
      for (int c = 0; c < CH; c++) begin
         if (rst_i) begin
            m_left[c] = 0;
            m_mode[c] = 1'b0;
            m_clk[c]  = 1'b0;
            m_tick[c] = 1'b0;
         end else if (sync_i || !en_i[c]) begin
            m_left[c] = int'(count_i[c*CW +: CW]);
            m_mode[c] = mode_i[c];
            m_clk[c]  = 1'b0;
            m_tick[c] = 1'b0;
         end else if (m_left[c] == 0) begin
            m_tick[c] = 1'b1;
            m_clk[c]  = m_mode[c] ? 1'b1 : !m_clk[c];
            m_left[c] = int'(count_i[c*CW +: CW]);
            m_mode[c] = mode_i[c];
         end else begin
            m_left[c] = m_left[c] - 1;
            m_tick[c] = 1'b0;
            if (m_mode[c]) m_clk[c] = 1'b0;
         end
      end
   end

   always @(negedge clk_i) begin
      if (cmp_on) begin
         checks++;
         if (clk_o !== m_clk) begin
            failures++;
            $display("FAIL model_clk t=%0t actual=%b required=%b", $time, clk_o, m_clk);
         end
         checks++;
         if (tick_o !== m_tick) begin
            failures++;
            $display("FAIL model_tick t=%0t actual=%b required=%b", $time, tick_o, m_tick);
         end
      end
   end

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic step(output logic [CH-1:0] c, output logic [CH-1:0] t);
      @(posedge clk_i);
      #1;
      c = clk_o;
      t = tick_o;
   endtask

   task automatic set_cnt(input int ch, input int val);
      count_i[ch*CW +: CW] = CW'(val);
   endtask

   logic [CH-1:0] sc, st;
   int hi [CH];
   int tk0, first0, first1, next1, rise0, fall0, rise0b;
   logic prev0, prev1;

   initial begin
      #2;
      cmp_on = 1'b1;
      repeat (3) step(sc, st);
      rst_i = 1'b0;

      // Idle with enables low.
      set_cnt(0, 3); set_cnt(1, 4); set_cnt(2, 0); set_cnt(3, 0);
      mode_i = 4'b1010;
      repeat (20) step(sc, st);
      chk("idle_clk", int'(sc), 0);
      chk("idle_tick", int'(st), 0);

      // Toggle N=3, pulse N=4, toggle N=0, pulse N=0 over 40 edges from E0.
      en_i = '1;
      for (int c = 0; c < CH; c++) hi[c] = 0;
      tk0 = 0; first0 = -1;
      for (int k = 0; k < 40; k++) begin
         step(sc, st);
         for (int c = 0; c < CH; c++) hi[c] += int'(sc[c]);
         tk0 += int'(st[0]);
         if (sc[0] && first0 < 0) first0 = k;
      end
      chk("ch0_first_high", first0, 3);
      chk("ch0_high_count", hi[0], 20);
      chk("ch0_tick_count", tk0, 10);
      chk("ch1_pulse_count", hi[1], 8);
      chk("ch2_div2_count", hi[2], 20);
      chk("ch3_const_high", hi[3], 40);

      // Reload mid-period: N=5, switch to N=1 at cnt=2.
      en_i = '0;
      set_cnt(0, 5); mode_i = '0;
      step(sc, st);
      en_i = 4'b0001;
      rise0 = -1; fall0 = -1; rise0b = -1; prev0 = 1'b0;
      for (int k = 0; k < 14; k++) begin
         step(sc, st);
         if (k == 2) set_cnt(0, 1);
         if (sc[0] && !prev0) begin
            if (rise0 < 0) rise0 = k; else if (rise0b < 0) rise0b = k;
         end
         if (!sc[0] && prev0 && fall0 < 0) fall0 = k;
         prev0 = sc[0];
      end
      chk("reload_rise", rise0, 5);
      chk("reload_fall", fall0, 7);
      chk("reload_rise2", rise0b, 9);

      // Sync alignment of two out-of-phase channels.
      en_i = '0;
      set_cnt(0, 3); set_cnt(1, 7); mode_i = '0;
      step(sc, st);
      en_i = 4'b0001;
      repeat (5) step(sc, st);
      en_i = 4'b0011;
      repeat (10) step(sc, st);
      sync_i = 1'b1;
      step(sc, st);
      sync_i = 1'b0;
      chk("sync_clears", int'(sc[1:0]), 0);
      first0 = -1; first1 = -1; next1 = -1; prev1 = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         step(sc, st);
         if (sc[0] && first0 < 0) first0 = k;
         if (sc[1] && !prev1) begin
            if (first1 < 0) first1 = k; else if (next1 < 0) next1 = k;
         end
         prev1 = sc[1];
      end
      chk("sync_ch0_rise", first0, 4);
      chk("sync_ch1_rise", first1, 8);
      chk("sync_ch1_next", next1, 24);

      // Asynchronous reset between edges.
      en_i = '0;
      set_cnt(3, 0); mode_i = 4'b1000;
      step(sc, st);
      en_i = 4'b1000;
      repeat (3) step(sc, st);
      chk("pre_reset_high", int'(sc[3]), 1);
      #2 rst_i = 1'b1;
      #1;
      chk("async_reset_clk", int'(clk_o), 0);
      chk("async_reset_tick", int'(tick_o), 0);
      repeat (2) step(sc, st);
      rst_i = 1'b0;
      step(sc, st);

      // Randomised run.
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(15) == 0) en_i[c] = ~en_i[c];
            if ($urandom_range(19) == 0) mode_i[c] = ~mode_i[c];
            if ($urandom_range(7) == 0) set_cnt(c, int'($urandom_range(9)));
         end
         sync_i = ($urandom_range(63) == 0);
         if ($urandom_range(499) == 0) begin
            rst_i = 1'b1;
            step(sc, st);
            rst_i = 1'b0;
         end
         step(sc, st);
      end

      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
